bf_stage_feeder: RTL and testbench

// Upstream feeder for the radix-2 butterfly. Collects N-sample blocks from a

---
 rtl/bf_stage_feeder.sv | 198 +++++++++++++++++++
 tb/tb_bf_stage_feeder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf_stage_feeder.sv
// ---------------------------------------------------------------------------
// bf_stage_feeder
//
// Upstream feeder for a radix-2 DIF butterfly (first stage). Incoming samples
// are collected into two ping-pong banks of N words. Once a bank is full it is
// drained as N/2 pairs (buffer[i], buffer[i+N/2]) with twiddle index i, while
// the other bank keeps filling.
//
// Ports
//   clk      in   1        clock, rising edge
//   rst_n    in   1        asynchronous active-low reset
//   in_data  in   WIDTH    input sample (opaque, passed through)
//   in_nd    in   1        in_data valid this cycle
//   in_m     in   MWIDTH   block metadata, captured with sample 0 of a block
//   xa       out  WIDTH    buffer[i] of the draining bank
//   xb       out  WIDTH    buffer[i+N/2] of the draining bank
//   tw_addr  out  LOG_N-1  twiddle index i, aligned with xa/xb
//   x_nd     out  1        one-cycle pulse per issued pair
//   m_out    out  MWIDTH   block metadata on pair 0, zero on other pairs
//   error    out  1        sticky overflow flag (sample arrived for a full bank)
// ---------------------------------------------------------------------------
module bf_stage_feeder #(
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1,
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int X_GAP  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_nd,
  input  logic [MWIDTH-1:0] in_m,
  output logic [WIDTH-1:0]  xa,
  output logic [WIDTH-1:0]  xb,
  output logic [LOG_N-2:0]  tw_addr,
  output logic              x_nd,
  output logic [MWIDTH-1:0] m_out,
  output logic              error
);

  localparam int HALF = N / 2;
  localparam int HW   = LOG_N - 1;
  localparam int GW   = (X_GAP > 1) ? $clog2(X_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_GAP} state_t;

  state_t            r_state, w_state_next;
  logic [LOG_N-1:0]  r_wcnt;
  logic              r_wb;
  logic              r_rb;
  logic [1:0]        r_full;
  logic [MWIDTH-1:0] r_meta [2];
  logic [HW-1:0]     r_rcnt, w_rcnt_next;
  logic [GW-1:0]     r_gcnt, w_gcnt_next;

  // Each bank is split into a low half (indices 0..N/2-1) and a high half
  // (N/2..N-1) so that xa and xb each come from a single-read-port array.
  logic [WIDTH-1:0]  r_mem_lo [N];
  logic [WIDTH-1:0]  r_mem_hi [N];

  logic              w_last;
  logic              w_wb_busy;
  logic              w_accept;
  logic              w_drop;
  logic              w_wrap;
  logic [1:0]        w_free;
  logic [1:0]        w_set;
  logic [LOG_N-1:0]  w_waddr;
  logic [LOG_N-1:0]  w_raddr;

  assign w_last = (r_state == S_DRAIN) && (r_rcnt == HW'(HALF - 1));

  // A bank being freed by its last pair this cycle may accept a write in the
  // same cycle.
  assign w_wb_busy = r_full[r_wb] && !(w_last && (r_rb == r_wb));
  assign w_accept  = in_nd && !w_wb_busy;
  assign w_drop    = in_nd && w_wb_busy;
  assign w_wrap    = w_accept && (r_wcnt == LOG_N'(N - 1));

  assign w_free  = w_last ? (2'b01 << r_rb) : 2'b00;
  assign w_set   = w_wrap ? (2'b01 << r_wb) : 2'b00;
  assign w_waddr = {r_wb, r_wcnt[HW-1:0]};
  assign w_raddr = {r_rb, r_rcnt};

  // Sample storage (no reset: contents are qualified by the full flags).
  always_ff @(posedge clk) begin
    if (w_accept && !r_wcnt[LOG_N-1]) begin
      r_mem_lo[w_waddr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && r_wcnt[LOG_N-1]) begin
      r_mem_hi[w_waddr] <= in_data;
    end
  end

  // Write side: counter, bank select, metadata, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt    <= '0;
      r_wb      <= 1'b0;
      r_full    <= 2'b00;
      r_meta[0] <= '0;
      r_meta[1] <= '0;
      error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == '0) begin
          r_meta[r_wb] <= in_m;
        end
      end
      if (w_wrap) begin
        r_wb <= ~r_wb;
      end
      r_full <= (r_full & ~w_free) | w_set;
      if (w_drop) begin
        error <= 1'b1;
      end
    end
  end

  // Read FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
      r_gcnt  <= '0;
      r_rb    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rcnt  <= w_rcnt_next;
      r_gcnt  <= w_gcnt_next;
      if (w_last) begin
        r_rb <= ~r_rb;
      end
    end
  end

  // Read FSM: next state.
  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = r_rcnt;
    w_gcnt_next  = r_gcnt;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rb]) begin
          w_state_next = S_DRAIN;
          w_rcnt_next  = '0;
        end
      end
      S_DRAIN: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_rcnt_next = r_rcnt + 1'b1;
          if (X_GAP > 0) begin
            w_state_next = S_GAP;
            w_gcnt_next  = '0;
          end
        end
      end
      S_GAP: begin
        if (r_gcnt == GW'(X_GAP - 1)) begin
          w_state_next = S_DRAIN;
        end else begin
          w_gcnt_next = r_gcnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered pair outputs; data outputs hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xa      <= '0;
      xb      <= '0;
      tw_addr <= '0;
      m_out   <= '0;
      x_nd    <= 1'b0;
    end else begin
      x_nd <= 1'b0;
      if (r_state == S_DRAIN) begin
        x_nd    <= 1'b1;
        xa      <= r_mem_lo[w_raddr];
        xb      <= r_mem_hi[w_raddr];
        tw_addr <= r_rcnt;
        m_out   <= (r_rcnt == '0) ? r_meta[r_rb] : '0;
      end
    end
  end

endmodule

// File: tb/tb_bf_stage_feeder.sv
// Testbench for bf_stage_feeder: two instances (X_GAP=0 and X_GAP=7) sharing
// clock and reset. Stimulus pushes hand-computed pairs (with expected issue
// cycle) into per-instance queues; monitors pop and compare on every x_nd.
module tb_bf_stage_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  tw;
    logic        m;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Instance 0: X_GAP = 0
  logic [31:0] in_data0 = '0;
  logic        in_nd0 = 1'b0;
  logic [0:0]  in_m0 = '0;
  logic [31:0] xa0, xb0;
  logic [1:0]  tw0;
  logic        x_nd0;
  logic [0:0]  m_out0;
  logic        err0;

  bf_stage_feeder #(.WIDTH(32), .MWIDTH(1), .N(8), .LOG_N(3), .X_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_nd(in_nd0), .in_m(in_m0),
    .xa(xa0), .xb(xb0), .tw_addr(tw0), .x_nd(x_nd0), .m_out(m_out0), .error(err0)
  );

  // Instance 1: X_GAP = 7
  logic [31:0] in_data1 = '0;
  logic        in_nd1 = 1'b0;
  logic [0:0]  in_m1 = '0;
  logic [31:0] xa1, xb1;
  logic [1:0]  tw1;
  logic        x_nd1;
  logic [0:0]  m_out1;
  logic        err1;

  bf_stage_feeder #(.WIDTH(32), .MWIDTH(1), .N(8), .LOG_N(3), .X_GAP(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_nd(in_nd1), .in_m(in_m1),
    .xa(xa1), .xb(xb1), .tw_addr(tw1), .x_nd(x_nd1), .m_out(m_out1), .error(err1)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (rst_n && x_nd0) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected pair", {xa0, xb0, tw0, m_out0}, '0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0 pair", {xa0, xb0, tw0, m_out0}, {e.a, e.b, e.tw, e.m});
        chk("dut0 pair cycle", 96'(cyc), 96'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && x_nd1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected pair", {xa1, xb1, tw1, m_out1}, '0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 pair", {xa1, xb1, tw1, m_out1}, {e.a, e.b, e.tw, e.m});
        chk("dut1 pair cycle", 96'(cyc), 96'(e.at));
      end
    end
  end

  int last_e;

  task automatic put0(input logic [31:0] d, input logic m);
    @(negedge clk);
    in_data0 = d;
    in_nd0   = 1'b1;
    in_m0    = m;
    last_e   = cyc + 1;
  endtask

  task automatic put1(input logic [31:0] d, input logic m);
    @(negedge clk);
    in_data1 = d;
    in_nd1   = 1'b1;
    in_m1    = m;
    last_e   = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_nd0 = 1'b0;
      in_nd1 = 1'b0;
    end
  endtask

  // Push the 4 pairs of a block whose first value is base (values base..base+7).
  task automatic push_block(input int which, input logic [31:0] base, input logic m,
                            input int first_at, input int step);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.a  = base + 32'(k);
      e.b  = base + 32'(k + 4);
      e.tw = 2'(k);
      e.m  = (k == 0) ? m : 1'b0;
      e.at = first_at + k * step;
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic drain_wait;
    for (int i = 0; i < 400 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    if (q0.size() > 0 || q1.size() > 0) begin
      chk("pending pairs left", 96'(q0.size() + q1.size()), 96'(0));
      q0.delete();
      q1.delete();
    end
    idle(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    // Reset state
    idle(3);
    chk("reset x_nd", {95'd0, x_nd0}, 96'd0);
    chk("reset outputs", {xa0, xb0, tw0, m_out0, err0}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: reset mid-block
    for (int j = 1; j <= 5; j++) put0(32'(j), 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    chk("mid reset x_nd/error", {94'd0, x_nd0, err0}, 96'd0);
    rst_n = 1'b1;
    idle(1);
    for (int j = 10; j <= 17; j++) put0(32'(j), (j == 10));
    push_block(0, 32'd10, 1'b1, last_e + 2, 1);
    idle(1);
    drain_wait();
    chk("test1 error", {95'd0, err0}, 96'd0);

    // 2: single block
    for (int j = 1; j <= 8; j++) put0(32'(j), (j == 1));
    push_block(0, 32'd1, 1'b1, last_e + 2, 1);
    idle(1);
    drain_wait();
    chk("hold xa/xb/tw after drain", {xa0, xb0, tw0, m_out0}, {32'd4, 32'd8, 2'd3, 1'b0});

    // 3: four blocks back to back
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) put0(32'(100 * b + j + 1), (j == 0) && (b % 2 == 0));
      push_block(0, 32'(100 * b + 1), (b % 2 == 0), last_e + 2, 1);
    end
    idle(1);
    drain_wait();
    chk("stream error", {95'd0, err0}, 96'd0);

    // 5: one sample every 3 cycles
    for (int j = 1; j <= 8; j++) begin
      put0(32'(j), (j == 1));
      if (j < 8) idle(2);
    end
    push_block(0, 32'd1, 1'b1, last_e + 2, 1);
    idle(1);
    drain_wait();

    // 4: overflow on the X_GAP=7 instance
    for (int j = 1; j <= 8; j++) put1(32'(j), (j == 1));
    e0 = last_e;
    push_block(1, 32'd1, 1'b1, e0 + 2, 8);
    for (int j = 11; j <= 18; j++) put1(32'(j), (j == 11));
    push_block(1, 32'd11, 1'b1, e0 + 28, 8);
    for (int j = 21; j <= 28; j++) begin
      put1(32'(j), (j == 21));
      if (j == 21) chk("error before drop", {95'd0, err1}, 96'd0);
      if (j == 22) chk("error on first drop", {95'd0, err1}, 96'd1);
    end
    idle(1);
    drain_wait();
    chk("error sticky", {95'd0, err1}, 96'd1);
    // A fresh block after the drops must land cleanly (write pointer unchanged).
    for (int j = 31; j <= 38; j++) put1(32'(j), (j == 31));
    push_block(1, 32'd31, 1'b1, last_e + 2, 8);
    idle(1);
    drain_wait();
    chk("error still sticky", {95'd0, err1}, 96'd1);
    chk("dut0 error final", {95'd0, err0}, 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
